servant_uart_rx_mon: RTL and testbench
======================================

// Module: servant_uart_rx_mon
// PURPOSE
//  Receives the bit-banged UART stream that the servant SoC drives on its GPIO/q pin and decodes it into bytes.
//  Sits directly downstream of servant on the board top, tapping the same net as o_uart_tx.
//  Used for on-chip loopback self-test and for byte-level observation without an external terminal.
//  8N1, LSB first, idle-high line, mid-bit sampling, single-entry output holding register with valid/ready.
// PARAMETERS
//  CLK_HZ   32000000  wb_clk frequency in Hz
//  BAUD     115200    line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit, must be >= 4
//  SYNC_EN  1         1: 2-flop synchronizer on i_rx; 0: i_rx used directly (already synchronous)
// PORTS
//  wb_clk      in   1  system clock, single clock domain
//  wb_rst      in   1  asynchronous, active-high reset
//  i_rx        in   1  serial line from servant q; idle high
//  o_data      out  8  received byte, stable while o_valid
//  o_valid     out  1  byte available in holding register
//  i_ready     in   1  consumer accepts byte when o_valid && i_ready
//  o_frame_err out  1  one-cycle pulse: stop bit sampled low
//  o_overrun   out  1  sticky: byte completed while holding register full
//  i_ovr_clr   in   1  clears o_overrun (set wins if same cycle)
//  o_busy      out  1  FSM not in IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release by wb_clk): sync flops=1, FSM=IDLE, counters=0, o_data=0,
//    o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0. Reset mid-frame aborts the frame; no partial byte is output.
//  - rx_s = i_rx after SYNC_EN stages (2 cycles of latency when SYNC_EN=1).
//  - FSM states: IDLE, START, DATA, STOP, BREAK. bit_cnt counts 0..DIV-1; idx counts 0..7.
//  - IDLE: rx_s==0 -> START with bit_cnt=0.
//  - START: at bit_cnt==DIV/2-1, sample rx_s. If 1 -> IDLE (glitch rejected, nothing reported).
//    If 0 -> DATA with bit_cnt=0, idx=0.
//  - DATA: at bit_cnt==DIV-1, shift rx_s into shreg[idx] (LSB first) and reset bit_cnt.
//    idx==7 -> STOP.
//  - STOP: at bit_cnt==DIV-1, sample rx_s.
//    - 1: byte complete -> IDLE.
//    - 0: o_frame_err pulses the next cycle, byte discarded -> BREAK.
//  - BREAK: wait for rx_s==1, then IDLE. A held-low line produces exactly one frame_err.
//  - Byte complete:
//    - If !o_valid or (o_valid && i_ready) in that cycle, o_data<=shreg and o_valid<=1 on the next edge.
//      Complete-and-pop in the same cycle loads the new byte with no gap.
//    - Otherwise the byte is dropped, o_overrun<=1, and o_data keeps the old byte.
//  - o_valid falls the edge after o_valid && i_ready, unless a new byte loads in that same cycle.
//  - o_data must not change while o_valid && !i_ready.
//  - Latency: line falling edge of start bit -> o_valid = SYNC_EN*2 + 9*DIV + DIV/2 + 1 cycles (+/-1 for edge phase).
//  - Back-to-back frames: a new start bit is detected in the first IDLE cycle after STOP (0.5-bit stop margin).
//  - Counter widths: bit_cnt = $clog2(DIV); idx 3 bits; no wrap beyond DIV-1.
// STRUCTURE
//  - Shared include servant_uart_defs.vh: FSM state localparams (IDLE/START/DATA/STOP/BREAK),
//    the DIV computation macro, and the frame width (8 data bits). Shared with a future TX-side block.
//  - Sub-module servant_sync2: 2-flop synchronizer with async reset to 1, bypassed when SYNC_EN=0.
//  - All remaining logic (FSM, shift register, holding register, flags) lives in this module.
// TESTING (bench: CLK_HZ=1000000, BAUD=100000 -> DIV=10, SYNC_EN=1, drive i_rx from a task)
//  1. Send 0x55 then 0xA3 back-to-back, i_ready=1
//     -> o_valid pulses twice; o_data=0x55 then 0xA3; no error flags.
//  2. Low glitch of 3 cycles on an idle line
//     -> FSM returns to IDLE; no o_valid, no o_frame_err.
//  3. Send 0x3C with stop bit low, line held low for 30 bits, then released
//     -> exactly one o_frame_err pulse, no o_valid; next frame 0x81 received correctly.
//  4. i_ready=0, send 0x11, 0x22
//     -> o_data stays 0x11 and o_valid stays 1; o_overrun=1 after the 0x22 stop bit.
//        i_ready=1 pops 0x11; i_ovr_clr clears overrun.
//  5. Hold i_ready=0, send 0x11; raise i_ready in exactly the cycle 0x22 completes
//     -> 0x22 loads with no overrun and o_valid stays high.
//  6. Assert wb_rst during bit 4 of 0xF0, release, send 0x0F
//     -> all outputs 0 immediately on reset; only 0x0F is reported.

Source files
------------

// File: rtl/servant_uart_rx_mon_pkg.sv
// Shared types and helpers for the servant UART receive monitor.
package servant_uart_rx_mon_pkg;

    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + (baud / 2)) / baud;
    endfunction

endpackage

// File: rtl/servant_sync2.sv
// Two-flop synchronizer resetting to the idle-high line level; bypassed when SYNC_EN=0.
module servant_sync2 #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (SYNC_EN) begin : g_sync
            logic meta_d, meta_q;
            logic sync_d, sync_q;

            always_comb begin
                meta_d = d;
                sync_d = meta_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_q <= 1'b1;
                    sync_q <= 1'b1;
                end else begin
                    meta_q <= meta_d;
                    sync_q <= sync_d;
                end
            end

            assign q = sync_q;
        end else begin : g_bypass
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/servant_uart_rx_mon.sv
// 8N1 UART receiver tapping servant's serial output; decodes bytes into a valid/ready holding register.
module servant_uart_rx_mon
    import servant_uart_rx_mon_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 32000000,
    parameter int unsigned BAUD    = 115200,
    parameter bit          SYNC_EN = 1'b1
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  i_rx,
    output logic [FRAME_BITS-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_frame_err,
    output logic                  o_overrun,
    input  logic                  i_ovr_clr,
    output logic                  o_busy
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
    localparam int unsigned BCW = $clog2(DIV);

    logic rx_s;

    rx_state_e             state_d, state_q;
    logic [BCW-1:0]        bit_cnt_d, bit_cnt_q;
    logic [IDX_W-1:0]      idx_d, idx_q;
    logic [FRAME_BITS-1:0] shreg_d, shreg_q;
    logic [FRAME_BITS-1:0] data_d, data_q;
    logic                  valid_d, valid_q;
    logic                  ferr_d, ferr_q;
    logic                  ovr_d, ovr_q;
    logic                  busy_d, busy_q;

    logic bit_last;
    logic bit_half;
    logic byte_done;
    logic pop;

    servant_sync2 #(
        .SYNC_EN (SYNC_EN)
    ) u_sync (
        .clk (wb_clk),
        .rst (wb_rst),
        .d   (i_rx),
        .q   (rx_s)
    );

    assign bit_last = (bit_cnt_q == BCW'(DIV - 1));
    assign bit_half = (bit_cnt_q == BCW'((DIV / 2) - 1));
    assign pop      = valid_q && i_ready;

    // Frame decoder: start qualification at half bit, data/stop sampled at end of each bit period.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_half) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    bit_cnt_d      = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == IDX_W'(FRAME_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    bit_cnt_d = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            ST_BREAK: begin
                bit_cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Holding register: a completed byte loads if the slot is empty or being popped this cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        busy_d  = (state_d != ST_IDLE);

        if (pop) begin
            valid_d = 1'b0;
        end
        if (i_ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (byte_done) begin
            if (!valid_q || pop) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_servant_uart_rx_mon.sv
// Scoreboard bench for servant_uart_rx_mon at DIV=10 with the synchronizer enabled.
module tb_servant_uart_rx_mon;

    localparam int unsigned DIV = 10;

    logic       wb_clk = 1'b0;
    logic       wb_rst;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;
    logic       i_ovr_clr;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;
    int ferr_cnt = 0;

    logic [7:0] exp_q[$];

    servant_uart_rx_mon #(
        .CLK_HZ  (1000000),
        .BAUD    (100000),
        .SYNC_EN (1'b1)
    ) dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .i_ovr_clr   (i_ovr_clr),
        .o_busy      (o_busy)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    task automatic line_bit(input logic b);
        i_rx = b;
        tick(DIV);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            line_bit(b[i]);
        end
        line_bit(stop);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor: samples after inputs settle; a pop happens on the next rising edge.
    always begin
        logic [7:0] e;
        @(negedge wb_clk);
        #2;
        if (o_frame_err) ferr_cnt++;
        if (o_valid && i_ready) begin
            checks++;
            pop_cnt++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected got=%02h exp=none", o_data);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    failures++;
                    $display("FAIL pop_data got=%02h exp=%02h", o_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst    = 1'b1;
        i_rx      = 1'b1;
        i_ready   = 1'b0;
        i_ovr_clr = 1'b0;
        tick(3);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_ferr", 32'(o_frame_err), 0);
        check("rst_ovr", 32'(o_overrun), 0);
        check("rst_busy", 32'(o_busy), 0);
        wb_rst = 1'b0;
        tick(5);

        // 1: back-to-back frames
        i_ready = 1'b1;
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        exp_q.push_back(8'hA3);
        send_byte(8'hA3, 1'b1);
        tick(5);
        check("t1_pops", pop_cnt, 2);
        check("t1_ferr", ferr_cnt, 0);
        check("t1_ovr", 32'(o_overrun), 0);

        // 2: short low glitch
        i_rx = 1'b0;
        tick(3);
        i_rx = 1'b1;
        tick(2);
        check("t2_busy_start", 32'(o_busy), 1);
        tick(20);
        check("t2_busy_idle", 32'(o_busy), 0);
        check("t2_pops", pop_cnt, 2);
        check("t2_ferr", ferr_cnt, 0);

        // 3: frame error with held-low line, then recovery
        send_byte(8'h3C, 1'b0);
        tick(300);
        check("t3_busy_break", 32'(o_busy), 1);
        i_rx = 1'b1;
        tick(30);
        check("t3_ferr_once", ferr_cnt, 1);
        check("t3_valid", 32'(o_valid), 0);
        check("t3_busy_idle", 32'(o_busy), 0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        tick(5);
        check("t3_pops", pop_cnt, 3);
        check("t3_ferr_after", ferr_cnt, 1);

        // 4: overrun while holding register full
        i_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        check("t4_valid1", 32'(o_valid), 1);
        check("t4_data1", 32'(o_data), 32'h11);
        check("t4_ovr0", 32'(o_overrun), 0);
        send_byte(8'h22, 1'b1);
        check("t4_valid2", 32'(o_valid), 1);
        check("t4_data2", 32'(o_data), 32'h11);
        check("t4_ovr1", 32'(o_overrun), 1);
        i_ready = 1'b1;
        tick(3);
        check("t4_pops", pop_cnt, 4);
        check("t4_valid_low", 32'(o_valid), 0);
        check("t4_ovr_sticky", 32'(o_overrun), 1);
        i_ovr_clr = 1'b1;
        tick(1);
        i_ovr_clr = 1'b0;
        tick(1);
        check("t4_ovr_clr", 32'(o_overrun), 0);

        // 5: pop in the exact completion cycle of the next byte
        i_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        exp_q.push_back(8'h22);
        fork
            send_byte(8'h22, 1'b1);
            begin
                tick(97);
                i_ready = 1'b1;
                tick(1);
                check("t5_valid", 32'(o_valid), 1);
                check("t5_data", 32'(o_data), 32'h22);
                check("t5_ovr", 32'(o_overrun), 0);
            end
        join
        tick(3);
        check("t5_pops", pop_cnt, 6);
        check("t5_ovr_end", 32'(o_overrun), 0);

        // 6: reset mid-frame
        i_ready = 1'b0;
        send_byte(8'h5A, 1'b1);
        check("t6_pre_valid", 32'(o_valid), 1);
        check("t6_pre_data", 32'(o_data), 32'h5A);
        fork
            send_byte(8'hF0, 1'b1);
            begin
                tick(55);
                wb_rst = 1'b1;
                #1;
                check("t6_rst_valid", 32'(o_valid), 0);
                check("t6_rst_data", 32'(o_data), 0);
                check("t6_rst_busy", 32'(o_busy), 0);
                check("t6_rst_ferr", 32'(o_frame_err), 0);
                check("t6_rst_ovr", 32'(o_overrun), 0);
                tick(3);
                wb_rst = 1'b0;
            end
        join
        tick(5);
        check("t6_no_partial", 32'(o_valid), 0);
        i_ready = 1'b1;
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1);
        tick(5);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            tick(1);
        end
        check("drain", exp_q.size(), 0);
        check("total_pops", pop_cnt, 7);
        check("total_ferr", ferr_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
